// File: rtl/sram_pkg.sv
// Shared types and default sizes for the SRAM arbiter and its read-tag tracker.
package sram_pkg;

  // Defaults matching the single sram_top instance (1024 x 8, one cycle read latency)
  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_RD_LAT = 1;

  // Requester identity carried alongside every in-flight read
  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // One SRAM command as seen by clients sized to the default array
  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_cmd_t;

endpackage : sram_pkg

// File: rtl/sram_rd_tracker.sv
// Shift pipe of read tags: one {valid, id} per issued command, exiting exactly
// when the SRAM presents the matching read data.
module sram_rd_tracker
  import sram_pkg::*;
#(
  parameter int DEPTH = SRAM_RD_LAT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_valid_i,
  input  req_id_t push_id_i,
  output logic    pop_valid_o,
  output req_id_t pop_id_o
);

  logic    valid_q [DEPTH];
  req_id_t id_q    [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic    valid_d;
      req_id_t id_d;

      if (gi == 0) begin : g_head
        assign valid_d = push_valid_i;
        assign id_d    = push_id_i;
      end else begin : g_body
        assign valid_d = valid_q[gi-1];
        assign id_d    = id_q[gi-1];
      end

      // Advance one stage per clock; reset drops every in-flight tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[gi] <= 1'b0;
          id_q[gi]    <= REQ0;
        end else begin
          valid_q[gi] <= valid_d;
          id_q[gi]    <= id_d;
        end
      end
    end
  endgenerate

  assign pop_valid_o = valid_q[DEPTH-1];
  assign pop_id_o    = id_q[DEPTH-1];

endmodule : sram_rd_tracker

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM.
// One command per clock; read data is steered back to the requester that issued it.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int RD_LAT = SRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  // SRAM bus
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  req_id_t           last_q;      // requester granted most recently
  logic [ADDR_W-1:0] addr_q;      // last address driven onto the bus
  logic [DATA_W-1:0] din_q;       // last write data driven onto the bus
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              gnt0, gnt1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic              rd_push;
  req_id_t           rd_id;
  logic              tag_valid;
  req_id_t           tag_id;

  // Round-robin grant; gated by rst_n so ready reads 0 while reset is held
  always_comb begin
    gnt0 = rst_n && req0_valid && (!req1_valid || (last_q == REQ1));
    gnt1 = rst_n && req1_valid && (!req0_valid || (last_q == REQ0));
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Route the granted command to the bus; otherwise replay the held values
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = addr_q;
    sel_din  = din_q;
    rd_push  = 1'b0;
    rd_id    = REQ0;
    if (gnt0) begin
      sel_we   = req0_we;
      sel_addr = req0_addr;
      sel_din  = req0_wdata;
      rd_push  = !req0_we;
      rd_id    = REQ0;
    end else if (gnt1) begin
      sel_we   = req1_we;
      sel_addr = req1_addr;
      sel_din  = req1_wdata;
      rd_push  = !req1_we;
      rd_id    = REQ1;
    end
  end

  assign sram_we   = sel_we;
  assign sram_addr = sel_addr;
  assign sram_din  = sel_din;

  // Pointer moves only on an accepted transfer; the bus value is held while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ1;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      if (gnt0) begin
        last_q <= REQ0;
      end else if (gnt1) begin
        last_q <= REQ1;
      end
      addr_q <= sel_addr;
      din_q  <= sel_din;
    end
  end

  sram_rd_tracker #(
    .DEPTH (RD_LAT)
  ) u_rd_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (rd_push),
    .push_id_i    (rd_id),
    .pop_valid_o  (tag_valid),
    .pop_id_o     (tag_id)
  );

  // Exiting tag selects which requester sees this cycle's SRAM data
  always_comb begin
    rsp0_valid = tag_valid && (tag_id == REQ0);
    rsp1_valid = tag_valid && (tag_id == REQ1);
    rsp0_rdata = rsp0_valid ? sram_dout : rdata0_q;
    rsp1_rdata = rsp1_valid ? sram_dout : rdata1_q;
  end

  // Keep the last delivered read data visible between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rdata0_q <= rsp0_rdata;
      rdata1_q <= rsp1_rdata;
    end
  end

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter driving a behavioural 1024 x 8 SRAM with one cycle read latency.
module tb_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Behavioural sram_top: synchronous write, registered read
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    sram_dout <= mem[sram_addr];
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic          v0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0, r1, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } vec_t;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            rsp1_cnt = 0;
  exp_t          sb_q [$];
  logic [DW-1:0] model_mem [1024];
  vec_t          vecs [17];

  function automatic vec_t mk(logic v0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic v1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                              logic r0, logic r1, logic we, logic [AW-1:0] addr,
                              logic [DW-1:0] din);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.we = we; v.addr = addr; v.din = din;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic v0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                       logic v1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1);
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic take(logic id, logic [DW-1:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("rsp_unexpected_queue_depth", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_id", {31'd0, id}, {31'd0, e.id});
      chk("rsp_data", {24'd0, data}, {24'd0, e.data});
      chk("rsp_cycle", cyc, e.cyc);
      if (id) rsp1_cnt++;
    end
  endtask

  // Scoreboard step for one clock: check responses, then record this cycle's accepts
  task automatic monitor();
    exp_t e;
    cyc++;
    chk("rsp_exclusive", {31'd0, rsp0_valid & rsp1_valid}, 0);
    chk("ready0_without_valid", {31'd0, req0_ready & ~req0_valid}, 0);
    chk("ready1_without_valid", {31'd0, req1_ready & ~req1_valid}, 0);
    if (rsp0_valid) take(1'b0, rsp0_rdata);
    if (rsp1_valid) take(1'b1, rsp1_rdata);
    if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      chk("rsp_missing_due_cycle", e.cyc, cyc + 1);
    end
    if (req0_valid && req0_ready) begin
      if (req0_we) model_mem[req0_addr] = req0_wdata;
      else sb_q.push_back({1'b0, model_mem[req0_addr], 32'(cyc + 1)});
    end
    if (req1_valid && req1_ready) begin
      if (req1_we) model_mem[req1_addr] = req1_wdata;
      else sb_q.push_back({1'b1, model_mem[req1_addr], 32'(cyc + 1)});
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 0);
    chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 0);
    chk({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 0);
    chk({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 0);
    chk({tag, "_rsp0_rdata"}, {24'd0, rsp0_rdata}, 0);
    chk({tag, "_rsp1_rdata"}, {24'd0, rsp1_rdata}, 0);
    chk({tag, "_sram_we"}, {31'd0, sram_we}, 0);
    chk({tag, "_sram_addr"}, {22'd0, sram_addr}, 0);
    chk({tag, "_sram_din"}, {24'd0, sram_din}, 0);
  endtask

  initial begin
    // Power-up reset with both requesters asking: every output must read 0
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 10'd7, 8'h55, 1'b1, 1'b0, 10'd9, 8'h00);
    #12;
    chk_all_zero("por");
    drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester, contention, same-cycle write/read, idle bus
    vecs[0]  = mk(1, 1, 10'd5,  8'hA5, 0, 0, 10'd0,  8'h00, 1, 0, 1, 10'd5,  8'hA5);
    vecs[1]  = mk(1, 0, 10'd5,  8'hA5, 0, 0, 10'd0,  8'h00, 1, 0, 0, 10'd5,  8'hA5);
    vecs[2]  = mk(0, 0, 10'd0,  8'h00, 0, 0, 10'd0,  8'h00, 0, 0, 0, 10'd5,  8'hA5);
    vecs[3]  = mk(0, 0, 10'd0,  8'h00, 1, 1, 10'd12, 8'h77, 0, 1, 1, 10'd12, 8'h77);
    vecs[4]  = mk(1, 1, 10'd10, 8'h3C, 1, 0, 10'd10, 8'h3C, 1, 0, 1, 10'd10, 8'h3C);
    vecs[5]  = mk(1, 1, 10'd10, 8'h3C, 1, 0, 10'd10, 8'h3C, 0, 1, 0, 10'd10, 8'h3C);
    vecs[6]  = mk(1, 1, 10'd10, 8'h3C, 1, 0, 10'd10, 8'h3C, 1, 0, 1, 10'd10, 8'h3C);
    vecs[7]  = mk(1, 1, 10'd10, 8'h3C, 1, 0, 10'd10, 8'h3C, 0, 1, 0, 10'd10, 8'h3C);
    vecs[8]  = mk(0, 0, 10'd0,  8'h00, 0, 0, 10'd0,  8'h00, 0, 0, 0, 10'd10, 8'h3C);
    vecs[9]  = mk(0, 0, 10'd0,  8'h00, 1, 0, 10'd12, 8'h3C, 0, 1, 0, 10'd12, 8'h3C);
    vecs[10] = mk(1, 1, 10'd3,  8'hFF, 1, 0, 10'd3,  8'hFF, 1, 0, 1, 10'd3,  8'hFF);
    vecs[11] = mk(0, 0, 10'd0,  8'h00, 1, 0, 10'd3,  8'hFF, 0, 1, 0, 10'd3,  8'hFF);
    for (int i = 12; i < 17; i++)
      vecs[i] = mk(0, 0, 10'd0, 8'h00, 0, 0, 10'd0, 8'h00, 0, 0, 0, 10'd3, 8'hFF);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      sample();
      $display("vec %0d: rdy0=%b rdy1=%b we=%b addr=%0h din=%0h rsp0=%b rsp1=%b",
               i, req0_ready, req1_ready, sram_we, sram_addr, sram_din, rsp0_valid, rsp1_valid);
      chk($sformatf("vec%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].r0});
      chk($sformatf("vec%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].r1});
      chk($sformatf("vec%0d_sram_we", i), {31'd0, sram_we}, {31'd0, vecs[i].we});
      chk($sformatf("vec%0d_sram_addr", i), {22'd0, sram_addr}, {22'd0, vecs[i].addr});
      chk($sformatf("vec%0d_sram_din", i), {24'd0, sram_din}, {24'd0, vecs[i].din});
      advance();
    end

    // Back-to-back: preload 0..7 from requester 1, then read them on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b1, 10'(i), 8'(8'h10 + i));
      sample();
      $display("preload addr %0d data %0h rdy1=%b", i, 8'(8'h10 + i), req1_ready);
      chk("preload_ready1", {31'd0, req1_ready}, 1);
      advance();
    end
    rsp1_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 10'(i), 8'h00);
      sample();
      $display("b2b read addr %0d rdy1=%b rsp1=%b rdata=%0h", i, req1_ready, rsp1_valid, rsp1_rdata);
      chk("b2b_ready1", {31'd0, req1_ready}, 1);
      advance();
    end
    drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      sample();
      advance();
    end
    chk("b2b_rsp1_count", rsp1_cnt, 8);

    // Reset mid-stream with a read in flight
    drive(1'b1, 1'b0, 10'd5, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
    sample();
    $display("inflight read addr 5 rdy0=%b", req0_ready);
    chk("inflight_ready0", {31'd0, req0_ready}, 1);
    advance();
    drive(1'b1, 1'b1, 10'd9, 8'h66, 1'b1, 1'b0, 10'd4, 8'h00);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 10'd0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      $display("post-reset cycle %0d rsp0=%b rsp1=%b", i, rsp0_valid, rsp1_valid);
      chk("postrst_rsp0_valid", {31'd0, rsp0_valid}, 0);
      chk("postrst_rsp1_valid", {31'd0, rsp1_valid}, 0);
      advance();
    end

    // Drain anything still outstanding, bounded
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      sample();
      advance();
    end
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sram_arbiter
